// File: rtl/masked_sbox_sched.sv
// masked_sbox_sched: arbitrates the key-schedule and round-state byte streams
// onto one shared masked S-box core. It attaches one fresh randomness word to
// each byte, tracks every issued byte through the core with a tag pipeline, and
// routes each core result back to the stream that issued it.
//
// Handshake: a word moves on a stream in every cycle where valid and ready are
// both high on the rising edge. valid must not depend on ready. The result
// streams (ks_rvalid/st_rvalid) cannot apply backpressure.
module masked_sbox_sched #(
   parameter int SHARES = 8,
   parameter int LAT    = 4,
   parameter int RND_W  = 56
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ks_valid,
   output logic                  ks_ready,
   input  logic                  ks_last,
   input  logic [SHARES*8-1:0]   ks_shares,
   input  logic                  st_valid,
   output logic                  st_ready,
   input  logic                  st_last,
   input  logic [SHARES*8-1:0]   st_shares,
   output logic                  ks_rvalid,
   output logic [SHARES*8-1:0]   ks_rshares,
   output logic                  st_rvalid,
   output logic [SHARES*8-1:0]   st_rshares,
   input  logic                  rnd_valid,
   output logic                  rnd_ready,
   input  logic [RND_W-1:0]      rnd_data,
   output logic                  sb_valid,
   output logic [SHARES*8-1:0]   sb_shares,
   output logic [RND_W-1:0]      sb_rnd,
   input  logic                  sb_ovalid,
   input  logic [SHARES*8-1:0]   sb_oshares,
   output logic                  busy,
   output logic                  err
);

   localparam int W = SHARES * 8;

   typedef enum logic [1:0] {IDLE = 2'd0, KS = 2'd1, ST = 2'd2} state_t;

   state_t          state;
   logic            last_was_st;   // previous burst went to ST; next tie goes to KS
   logic [3:0]      beat_cnt;      // transfers already taken in the current burst
   logic            xfer;
   logic            xfer_last;
   logic [W-1:0]    xfer_shares;
   logic            sb_id;         // requester of the byte now on sb_*: 1 = ST
   logic [LAT-1:0]  tag_v;
   logic [LAT-1:0]  tag_id;
   logic            tag_out_v;
   logic            tag_out_id;
   logic            overrun;

   assign tag_out_v  = tag_v[LAT-1];
   assign tag_out_id = tag_id[LAT-1];
   // sb_valid is the first pipeline stage ahead of the tags, so it counts as in flight
   assign busy       = (state != IDLE) || sb_valid || (|tag_v);

   // Readies follow randomness availability for the granted stream only
   always_comb begin
      ks_ready    = (state == KS) && rnd_valid;
      st_ready    = (state == ST) && rnd_valid;
      xfer        = (ks_valid && ks_ready) || (st_valid && st_ready);
      xfer_last   = (state == ST) ? st_last : ks_last;
      xfer_shares = (state == ST) ? st_shares : ks_shares;
      rnd_ready   = xfer;
      overrun     = xfer && !xfer_last && (beat_cnt == 4'd15);
   end

   // Grant FSM: round-robin on ties, bursts run to last or the 16-byte bound
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         last_was_st <= 1'b1;
         beat_cnt    <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               beat_cnt <= 4'd0;
               if (ks_valid && st_valid) begin
                  state       <= last_was_st ? KS : ST;
                  last_was_st <= !last_was_st;
               end else if (ks_valid) begin
                  state       <= KS;
                  last_was_st <= 1'b0;
               end else if (st_valid) begin
                  state       <= ST;
                  last_was_st <= 1'b1;
               end
            end
            KS, ST: begin
               if (xfer) begin
                  if (xfer_last || beat_cnt == 4'd15) begin
                     state    <= IDLE;
                     beat_cnt <= 4'd0;
                  end else begin
                     beat_cnt <= beat_cnt + 4'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Issue register toward the core; data holds between transfers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sb_valid  <= 1'b0;
         sb_shares <= '0;
         sb_rnd    <= '0;
         sb_id     <= 1'b0;
      end else begin
         sb_valid <= xfer;
         if (xfer) begin
            sb_shares <= xfer_shares;
            sb_rnd    <= rnd_data;
            sb_id     <= (state == ST);
         end
      end
   end

   // Tag pipeline: stage LAT-1 lines up with the core's output cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_v  <= '0;
         tag_id <= '0;
      end else begin
         for (int i = LAT - 1; i > 0; i--) begin
            tag_v[i]  <= tag_v[i-1];
            tag_id[i] <= tag_id[i-1];
         end
         tag_v[0]  <= sb_valid;
         tag_id[0] <= sb_id;
      end
   end

   // Result routing to the tagged requester; shares pass through untouched
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ks_rvalid  <= 1'b0;
         st_rvalid  <= 1'b0;
         ks_rshares <= '0;
         st_rshares <= '0;
      end else begin
         ks_rvalid <= tag_out_v && sb_ovalid && !tag_out_id;
         st_rvalid <= tag_out_v && sb_ovalid && tag_out_id;
         if (tag_out_v && sb_ovalid && !tag_out_id) ks_rshares <= sb_oshares;
         if (tag_out_v && sb_ovalid && tag_out_id)  st_rshares <= sb_oshares;
      end
   end

   // Sticky fault: core output out of step with the tags, or an unterminated burst
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err <= 1'b0;
      end else if (overrun || (sb_ovalid != tag_out_v)) begin
         err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_masked_sbox_sched.sv
// Bench for masked_sbox_sched: directed bursts, an identity-delay core stub that
// can drop one output, and queue-based scoreboards checked by a monitor.
module tb_masked_sbox_sched;

   localparam int SHARES = 8;
   localparam int LAT    = 4;
   localparam int RND_W  = 56;
   localparam int W      = SHARES * 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             ks_valid = 1'b0, ks_last = 1'b0;
   logic             st_valid = 1'b0, st_last = 1'b0;
   logic [W-1:0]     ks_shares = '0, st_shares = '0;
   logic             ks_ready, st_ready, ks_rvalid, st_rvalid;
   logic [W-1:0]     ks_rshares, st_rshares;
   logic             rnd_valid = 1'b0;
   logic             rnd_ready;
   logic [RND_W-1:0] rnd_data = '0;
   logic             sb_valid;
   logic [W-1:0]     sb_shares;
   logic [RND_W-1:0] sb_rnd;
   logic             sb_ovalid;
   logic [W-1:0]     sb_oshares;
   logic             busy, err;

   always #5 clk = ~clk;

   masked_sbox_sched #(.SHARES(SHARES), .LAT(LAT), .RND_W(RND_W)) dut (
      .clk(clk), .rst(rst),
      .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_last(ks_last), .ks_shares(ks_shares),
      .st_valid(st_valid), .st_ready(st_ready), .st_last(st_last), .st_shares(st_shares),
      .ks_rvalid(ks_rvalid), .ks_rshares(ks_rshares),
      .st_rvalid(st_rvalid), .st_rshares(st_rshares),
      .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_data(rnd_data),
      .sb_valid(sb_valid), .sb_shares(sb_shares), .sb_rnd(sb_rnd),
      .sb_ovalid(sb_ovalid), .sb_oshares(sb_oshares),
      .busy(busy), .err(err)
   );

   // ---------------- core stub: LAT-cycle identity delay ----------------
   logic [LAT-1:0] ov_pipe;
   logic [W-1:0]   sh_pipe [LAT];
   int             drop_req = 0;
   int             drop_ack = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ov_pipe <= '0;
         for (int i = 0; i < LAT; i++) sh_pipe[i] <= '0;
      end else begin
         for (int i = LAT - 1; i > 0; i--) begin
            ov_pipe[i] <= ov_pipe[i-1];
            sh_pipe[i] <= sh_pipe[i-1];
         end
         if (sb_valid && drop_req != drop_ack) begin
            ov_pipe[0] <= 1'b0;
            drop_ack   <= drop_ack + 1;
         end else begin
            ov_pipe[0] <= sb_valid;
         end
         sh_pipe[0] <= sb_shares;
      end
   end
   assign sb_ovalid  = ov_pipe[LAT-1];
   assign sb_oshares = sh_pipe[LAT-1];

   // ---------------- cycle counter and randomness source ----------------
   int cyc = 0;
   bit rnd_en = 1'b0;
   bit rnd_toggle = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      if (!rnd_en) begin
         rnd_valid = 1'b0;
         rnd_data  = '0;
      end else begin
         rnd_valid = rnd_toggle ? ~rnd_valid : 1'b1;
         rnd_data  = {24'ha5c3e1, 32'(cyc)};
      end
   end

   // ---------------- scoreboard state ----------------
   logic [96:0]  exp_q [$];   // {cycle, id (1=ST), shares}
   logic [151:0] iss_q [$];   // {cycle, rnd, shares}
   logic         xfer_ids [$];
   int           n_checks = 0;
   int           n_fail = 0;
   int           rnd_pulses = 0;
   int           sb_pulses = 0;
   bit           expect_result = 1'b1;
   int           last_xfer_cyc = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flag(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   function automatic logic [W-1:0] shares_of(input logic [7:0] b);
      return {8{b}} ^ 64'h0706050403020100;
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [151:0] ie;
      logic [96:0]  re;
      if (!rst) begin
         if (rnd_ready) rnd_pulses++;
         if (sb_valid)  sb_pulses++;
         if (rnd_ready) check("rnd_ready_needs_rnd_valid", 256'(rnd_valid), 256'(1));
         if (sb_valid) begin
            if (iss_q.size() == 0) flag("unexpected_sb_valid");
            else begin
               ie = iss_q.pop_front();
               check("sb_issue", 256'({32'(cyc), sb_rnd, sb_shares}), 256'(ie));
            end
         end
         if (ks_rvalid && st_rvalid) flag("both_rvalid");
         if (ks_rvalid || st_rvalid) begin
            if (exp_q.size() == 0) flag("unexpected_rvalid");
            else begin
               re = exp_q.pop_front();
               check("result", 256'({32'(cyc), st_rvalid, st_rvalid ? st_rshares : ks_rshares}), 256'(re));
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive_stream(input bit id, input int n, input bit with_last, input logic [7:0] base);
      for (int i = 0; i < n; i++) begin
         logic [7:0]   b;
         logic [W-1:0] sh;
         bit           got;
         int           waited;
         b  = base + 8'(i * 8'h11);
         sh = shares_of(b);
         if (id) begin
            st_valid = 1'b1; st_shares = sh; st_last = with_last && (i == n - 1);
         end else begin
            ks_valid = 1'b1; ks_shares = sh; ks_last = with_last && (i == n - 1);
         end
         got = 1'b0;
         waited = 0;
         while (!got && waited < 200) begin
            @(negedge clk);
            if (id ? st_ready : ks_ready) begin
               got = 1'b1;
               xfer_ids.push_back(id);
               iss_q.push_back({32'(cyc + 1), rnd_data, sh});
               if (expect_result) exp_q.push_back({32'(cyc + LAT + 2), id, sh});
               last_xfer_cyc = cyc;
            end else begin
               @(posedge clk); #1;
               waited++;
            end
         end
         if (!got) flag("handshake_timeout");
         @(posedge clk); #1;
      end
      if (id) begin st_valid = 1'b0; st_last = 1'b0; end
      else    begin ks_valid = 1'b0; ks_last = 1'b0; end
   endtask

   task automatic wait_drain();
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while ((exp_q.size() != 0 || iss_q.size() != 0 || busy) && k < 100);
      check("drain", 256'({16'(exp_q.size()), 16'(iss_q.size()), busy}), 256'(0));
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      ks_valid = 1'b0; ks_last = 1'b0; ks_shares = '0;
      st_valid = 1'b0; st_last = 1'b0; st_shares = '0;
      exp_q.delete();
      iss_q.delete();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   function automatic logic [255:0] all_outputs();
      return 256'({ks_ready, st_ready, ks_rvalid, ks_rshares, st_rvalid, st_rshares,
                   rnd_ready, sb_valid, sb_shares, sb_rnd, busy, err});
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      int c;
      int n;
      int k;

      // Reset release with every input at 0: everything stays 0
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("reset_idle_outputs", all_outputs(), 256'(0));
      end
      @(posedge clk); #1;

      // Single 4-byte KS burst, continuous randomness
      rnd_en = 1'b1;
      @(posedge clk); #1;
      xfer_ids.delete();
      drive_stream(1'b0, 4, 1'b1, 8'h11);
      wait_drain();
      check("ks_burst_count", 256'(xfer_ids.size()), 256'(4));
      check("ks_burst_no_err", 256'(err), 256'(0));

      // Simultaneous requests from reset: KS first, then a 16-byte ST burst
      do_reset();
      xfer_ids.delete();
      fork
         drive_stream(1'b0, 4, 1'b1, 8'h11);
         drive_stream(1'b1, 16, 1'b1, 8'h80);
      join
      wait_drain();
      check("tie_count", 256'(xfer_ids.size()), 256'(20));
      check("tie_first_is_ks", 256'({xfer_ids[0], xfer_ids[3]}), 256'(0));
      check("tie_then_st", 256'({xfer_ids[4], xfer_ids[19]}), 256'(2'b11));
      check("st16_no_err", 256'(err), 256'(0));
      xfer_ids.delete();
      fork
         drive_stream(1'b0, 1, 1'b1, 8'h5a);
         drive_stream(1'b1, 1, 1'b1, 8'ha5);
      join
      wait_drain();
      check("second_tie_ks_first", 256'({xfer_ids[0], xfer_ids[1]}), 256'(2'b01));

      // Randomness toggling: transfers only when rnd_valid is high
      rnd_pulses = 0;
      sb_pulses  = 0;
      rnd_toggle = 1'b1;
      xfer_ids.delete();
      drive_stream(1'b0, 6, 1'b1, 8'h03);
      wait_drain();
      rnd_toggle = 1'b0;
      check("toggle_rnd_pulses", 256'(rnd_pulses), 256'(6));
      check("toggle_sb_pulses", 256'(sb_pulses), 256'(6));
      check("toggle_xfers", 256'(xfer_ids.size()), 256'(6));

      // Core drops one output: err rises one cycle after the missing sb_ovalid
      @(posedge clk); #1;
      expect_result = 1'b0;
      drop_req = drop_req + 1;
      drive_stream(1'b0, 1, 1'b1, 8'h77);
      c = last_xfer_cyc;
      k = 0;
      while (cyc < c + LAT + 1 && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("drop_err_not_yet", 256'(err), 256'(0));
      @(negedge clk);
      check("drop_err_set", 256'(err), 256'(1));
      repeat (10) @(negedge clk);
      check("drop_err_sticky", 256'(err), 256'(1));
      expect_result = 1'b1;
      @(posedge clk); #1;
      wait_drain();

      // 17-byte ST stream without last: err after the 16th, FSM back in IDLE
      do_reset();
      check("err_cleared_by_reset", 256'(err), 256'(0));
      drive_stream(1'b1, 16, 1'b0, 8'h01);
      @(negedge clk);
      check("overrun_idle_err", 256'({st_ready, err}), 256'(2'b01));
      @(posedge clk); #1;
      drive_stream(1'b1, 1, 1'b1, 8'hf0);
      wait_drain();

      // Reset in the middle of an ST burst with 3 bytes in flight
      do_reset();
      st_valid = 1'b1;
      st_last = 1'b0;
      st_shares = shares_of(8'hc3);
      n = 0;
      k = 0;
      while (n < 3 && k < 50) begin
         @(negedge clk);
         if (st_ready) begin
            n++;
            iss_q.push_back({32'(cyc + 1), rnd_data, st_shares});
         end
         @(posedge clk); #1;
         k++;
      end
      check("midburst_transfers", 256'(n), 256'(3));
      #1;
      rst = 1'b1;
      st_valid = 1'b0;
      iss_q.delete();
      exp_q.delete();
      #1;
      check("async_reset_outputs", all_outputs(), 256'(0));
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("post_reset_quiet", 256'({ks_rvalid, st_rvalid, sb_valid, busy}), 256'(0));
      end

      check("queues_empty_at_end", 256'({16'(exp_q.size()), 16'(iss_q.size())}), 256'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global time limit so the run always ends
   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

endmodule

// File: doc/masked_sbox_sched.md
MASKED_SBOX_SCHED -- requirements
Module: masked_sbox_sched

Interface
REQ-001 SHALL have parameter SHARES, default 8: number of Boolean shares per byte.
REQ-002 SHALL have parameter LAT, default 4: fixed masked S-box core latency in cycles, legal range 1..8.
REQ-003 SHALL have parameter RND_W, default 56: fresh-randomness bits consumed per S-box evaluation.
REQ-004 SHALL have ports: clk in 1, single clock; all logic on rising edge.
REQ-005 SHALL have ports: rst in 1, asynchronous, active-high.
REQ-006 SHALL have ports: ks_valid in 1, ks_ready out 1, ks_last in 1, ks_shares in SHARES*8; key-schedule request stream.
REQ-007 SHALL have ports: st_valid in 1, st_ready out 1, st_last in 1, st_shares in SHARES*8; round-state request stream.
REQ-008 SHALL have ports: ks_rvalid out 1, ks_rshares out SHARES*8; key-schedule result, no backpressure.
REQ-009 SHALL have ports: st_rvalid out 1, st_rshares out SHARES*8; round-state result, no backpressure.
REQ-010 SHALL have ports: rnd_valid in 1, rnd_ready out 1, rnd_data in RND_W; randomness source stream.
REQ-011 SHALL have ports: sb_valid out 1, sb_shares out SHARES*8, sb_rnd out RND_W; issue to shared masked S-box core.
REQ-012 SHALL have ports: sb_ovalid in 1, sb_oshares in SHARES*8; core output.
REQ-013 SHALL have ports: busy out 1 and err out 1 (sticky fault).

Function
REQ-014 SHALL implement FSM states IDLE, KS, ST; in IDLE no ready is asserted.
REQ-015 SHALL leave IDLE when ks_valid or st_valid is high. If only one is high, it SHALL go to that requester's state. If both are high, it SHALL grant the requester not granted in the previous burst; the first grant after reset goes to KS.
REQ-016 SHALL, in KS (ST), drive ks_ready (st_ready) = rnd_valid; the other ready SHALL be 0.
REQ-017 SHALL define a transfer as valid&ready of the granted stream; rnd_ready SHALL equal the transfer, so exactly one rnd word is consumed per byte.
REQ-018 SHALL, for a transfer in cycle t, register sb_valid=1, sb_shares=input shares and sb_rnd=rnd_data in cycle t+1; otherwise sb_valid=0. Other outputs SHALL hold their last values.
REQ-019 SHALL treat a burst as ending on a transfer with last=1, returning to IDLE in the next cycle; no preemption within a burst.
REQ-020 SHALL bound a burst to 16 transfers; a 16th transfer without last SHALL set err and force return to IDLE.
REQ-021 SHALL keep a LAT-deep tag shift register (valid, requester id) aligned with the core pipeline.
REQ-022 SHALL expect sb_ovalid exactly LAT cycles after sb_valid.
REQ-023 SHALL set err when sb_ovalid differs from the tag valid in the same cycle.
REQ-024 SHALL route sb_oshares, registered, to the tagged requester's rshares with rvalid=1 one cycle later. Total latency from transfer to rvalid SHALL be LAT+2 cycles, results in issue order.
REQ-025 SHALL NOT modify shares; recombination is the requester's job.
REQ-026 SHALL drive busy=1 while state!=IDLE or any tag is valid.
REQ-027 SHALL keep err sticky until rst.
REQ-028 SHALL allow back-to-back bursts: KS->IDLE->ST costs one idle cycle, and in-flight tags continue draining.

Reset
REQ-029 SHALL, on rst assertion, immediately clear state to IDLE, clear all tags, and drive all valids/readies, busy and err to 0, with data outputs at 0. The round-robin pointer SHALL reset so the next tie goes to KS.
REQ-030 SHALL discard bytes in flight at reset; no rvalid SHALL appear after rst deasserts until a new transfer.

Verification
REQ-031 Reset release, all inputs 0 -> all outputs 0, busy=0, err=0 for 20 cycles.
REQ-032 LAT=4, identity-delay core stub, rnd_valid=1, 4-byte KS burst 0x11,0x22,0x33,0x44 (last on 4th) handshaking cycles 1-4 -> sb_valid high cycles 2-5, ks_rvalid high cycles 7-10 with 0x11..0x44 in order, st_rvalid never high.
REQ-033 ks_valid and st_valid both high from reset -> KS burst first, then ST 16-byte burst. Next simultaneous request -> KS granted.
REQ-034 rnd_valid toggled 1,0,1,0 during a burst -> transfers only in rnd_valid=1 cycles. Count of rnd_ready pulses equals count of sb_valid pulses.
REQ-035 Core stub suppresses one sb_ovalid -> err=1 in the expected cycle and held; a 17-byte ST stream without last -> err=1, FSM in IDLE after the 16th byte.
REQ-036 rst asserted mid-way through a ST burst with 3 bytes in flight -> outputs 0 asynchronously, and no st_rvalid after deassertion.
